// File: rtl/time_set_ctrl_if.sv
// Front-panel button / clock-core bus between the panel + clock core (master) and time_set_ctrl (slave).
interface time_set_ctrl_if;
    localparam int unsigned TIME_W = 17;

    logic              btn_mode;
    logic              btn_inc;
    logic              btn_dec;
    logic [TIME_W-1:0] time_cur;
    logic [TIME_W-1:0] time_in;
    logic              time_ow;
    logic [1:0]        edit_field;

    modport master (
        output btn_mode, btn_inc, btn_dec, time_cur,
        input  time_in, time_ow, edit_field
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, time_cur,
        output time_in, time_ow, edit_field
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced buttons drive an HH:MM:SS edit FSM that overwrites the clock core.
// Optional auto-repeat on held inc/dec is enabled with `define TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned TIMEOUT_CYCLES  = 10000000,
    parameter int unsigned REPEAT_DELAY    = 5000000,
    parameter int unsigned REPEAT_CYCLES   = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    time_set_ctrl_if.slave  bus
);
    localparam int unsigned NBTN     = 3;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned BTN_DEC  = 2;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HR_W     = 5;
    localparam int unsigned MS_W     = 6;
    localparam int unsigned TIME_W   = 17;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_e;

    function automatic logic [HR_W-1:0] hr_step(input logic [HR_W-1:0] v, input logic up);
        if (up) return (v >= HR_W'(23)) ? '0 : v + HR_W'(1);
        return (v == '0) ? HR_W'(23) : v - HR_W'(1);
    endfunction

    function automatic logic [MS_W-1:0] ms_step(input logic [MS_W-1:0] v, input logic up);
        if (up) return (v >= MS_W'(59)) ? '0 : v + MS_W'(1);
        return (v == '0) ? MS_W'(59) : v - MS_W'(1);
    endfunction

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] db_q, db_d;
    logic [NBTN-1:0] rise_c;
    logic [NBTN-1:0] press_q;
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [DB_W-1:0] db_cnt_d [NBTN];

    state_e            state_q, state_d;
    logic [HR_W-1:0]   hr_q, hr_d;
    logic [MS_W-1:0]   min_q, min_d;
    logic [MS_W-1:0]   sec_q, sec_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic [TIME_W-1:0] time_in_q, time_in_d;
    logic              time_ow_q, time_ow_d;
    logic [1:0]        edit_field_q, edit_field_d;

    logic       in_edit_c;
    logic [1:0] rp_fire_c;
    logic       inc_any_c, dec_any_c;
    logic       ev_mode_c, ev_inc_c, ev_dec_c;

    assign btn_raw = {bus.btn_dec, bus.btn_inc, bus.btn_mode};

    // Debounce: the level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_d   = db_q;
        rise_c = '0;
        for (int i = 0; i < NBTN; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i]   = sync2_q[i];
                    rise_c[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign in_edit_c = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] rp_cnt_q [2];
    logic [RP_W-1:0] rp_cnt_d [2];
    logic [1:0]      rp_arm_q, rp_arm_d;
    logic [1:0]      rp_lvl;

    assign rp_lvl = {db_q[BTN_DEC], db_q[BTN_INC]};

    // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_CYCLES.
    assign rp_fire_c[0] = in_edit_c && rp_lvl[0] &&
                          (rp_arm_q[0] ? (rp_cnt_q[0] == RP_W'(REPEAT_CYCLES))
                                       : (rp_cnt_q[0] == RP_W'(REPEAT_DELAY)));
    assign rp_fire_c[1] = in_edit_c && rp_lvl[1] &&
                          (rp_arm_q[1] ? (rp_cnt_q[1] == RP_W'(REPEAT_CYCLES))
                                       : (rp_cnt_q[1] == RP_W'(REPEAT_DELAY)));

    always_comb begin
        rp_arm_d = rp_arm_q;
        for (int j = 0; j < 2; j++) begin
            rp_cnt_d[j] = rp_cnt_q[j];
            if (!rp_lvl[j] || !in_edit_c || (state_d != state_q)) begin
                rp_cnt_d[j] = '0;
                rp_arm_d[j] = 1'b0;
            end else if (rp_fire_c[j]) begin
                rp_cnt_d[j] = RP_W'(1);
                rp_arm_d[j] = 1'b1;
            end else begin
                rp_cnt_d[j] = rp_cnt_q[j] + RP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_arm_q <= '0;
            for (int j = 0; j < 2; j++) rp_cnt_q[j] <= '0;
        end else begin
            rp_arm_q <= rp_arm_d;
            for (int j = 0; j < 2; j++) rp_cnt_q[j] <= rp_cnt_d[j];
        end
    end
`else
    logic unused_rp;
    assign unused_rp = ^{REPEAT_DELAY, REPEAT_CYCLES};
    assign rp_fire_c = '0;
`endif

    // Mode wins over inc/dec; inc together with dec cancels out.
    assign inc_any_c = press_q[BTN_INC] | rp_fire_c[0];
    assign dec_any_c = press_q[BTN_DEC] | rp_fire_c[1];
    assign ev_mode_c = press_q[BTN_MODE];
    assign ev_inc_c  = !ev_mode_c && inc_any_c && !dec_any_c;
    assign ev_dec_c  = !ev_mode_c && dec_any_c && !inc_any_c;

    always_comb begin
        state_d      = state_q;
        hr_d         = hr_q;
        min_d        = min_q;
        sec_d        = sec_q;
        idle_d       = idle_q;
        time_in_d    = time_in_q;
        time_ow_d    = 1'b0;
        edit_field_d = 2'd0;

        unique case (state_q)
            ST_RUN: begin
                idle_d = '0;
                if (ev_mode_c) begin
                    hr_d    = (bus.time_cur[16:12] > HR_W'(23)) ? '0 : bus.time_cur[16:12];
                    min_d   = (bus.time_cur[11:6]  > MS_W'(59)) ? '0 : bus.time_cur[11:6];
                    sec_d   = (bus.time_cur[5:0]   > MS_W'(59)) ? '0 : bus.time_cur[5:0];
                    state_d = ST_SET_HR;
                end
            end
            ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
                if (ev_mode_c) begin
                    idle_d  = '0;
                    state_d = (state_q == ST_SET_HR)  ? ST_SET_MIN :
                              (state_q == ST_SET_MIN) ? ST_SET_SEC : ST_COMMIT;
                end else if (ev_inc_c || ev_dec_c) begin
                    idle_d = '0;
                    unique case (state_q)
                        ST_SET_HR:  hr_d  = hr_step(hr_q, ev_inc_c);
                        ST_SET_MIN: min_d = ms_step(min_q, ev_inc_c);
                        default:    sec_d = ms_step(sec_q, ev_inc_c);
                    endcase
                end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            ST_COMMIT: begin
                idle_d  = '0;
                state_d = ST_RUN;
            end
            default: begin
                idle_d  = '0;
                state_d = ST_RUN;
            end
        endcase

        // time_in follows the edit registers only while editing; frozen in COMMIT/RUN.
        if (in_edit_c) time_in_d = {hr_q, min_q, sec_q};

        time_ow_d = (state_d == ST_COMMIT);
        unique case (state_d)
            ST_SET_HR:  edit_field_d = 2'd1;
            ST_SET_MIN: edit_field_d = 2'd2;
            ST_SET_SEC: edit_field_d = 2'd3;
            default:    edit_field_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            press_q      <= '0;
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
            state_q      <= ST_RUN;
            hr_q         <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            idle_q       <= '0;
            time_in_q    <= '0;
            time_ow_q    <= 1'b0;
            edit_field_q <= 2'd0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            press_q      <= rise_c;
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q      <= state_d;
            hr_q         <= hr_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            idle_q       <= idle_d;
            time_in_q    <= time_in_d;
            time_ow_q    <= time_ow_d;
            edit_field_q <= edit_field_d;
        end
    end

    assign bus.time_in    = time_in_q;
    assign bus.time_ow    = time_ow_q;
    assign bus.edit_field = edit_field_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random button traffic, checked every cycle against a behavioural model.
module tb_time_set_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned TO = 50;
    localparam int unsigned RD = 10;
    localparam int unsigned RC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  btn;
    logic [16:0] tcur;

    always #5 clk = ~clk;

    time_set_ctrl_if bus ();
    assign bus.btn_mode = btn[0];
    assign bus.btn_inc  = btn[1];
    assign bus.btn_dec  = btn[2];
    assign bus.time_cur = tcur;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .REPEAT_DELAY   (RD),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ow_cycles = 0;
    bit chk_en = 1'b0;

    // Behavioural model: 0 = running, 1..3 = editing hours/minutes/seconds, 4 = commit.
    int          m_sy1 [3];
    int          m_sy2 [3];
    int          m_db  [3];
    int          m_run [3];
    int          m_prs [3];
    int          m_f   [3];
    int          m_held[2];
    int          m_st, m_idle, m_ow, m_fld;
    logic [16:0] m_tin;
    int          modv [3] = '{24, 60, 60};

    function automatic logic [16:0] pack(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic model_step();
        int o_st;
        int fire [2];
        int ei, ed, em, dlt;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_sy1[i] = 0; m_sy2[i] = 0; m_db[i] = 0; m_run[i] = 0; m_prs[i] = 0; m_f[i] = 0;
            end
            m_held[0] = 0; m_held[1] = 0;
            m_st = 0; m_idle = 0; m_ow = 0; m_fld = 0; m_tin = '0;
            return;
        end
        o_st = m_st;
        fire[0] = 0; fire[1] = 0;
`ifdef TIME_SET_AUTO_REPEAT_EN
        for (int j = 0; j < 2; j++)
            if (o_st >= 1 && o_st <= 3 && m_db[1+j] == 1 && m_held[j] >= int'(RD) &&
                ((m_held[j] - int'(RD)) % int'(RC)) == 0)
                fire[j] = 1;
`endif
        em = m_prs[0];
        ei = (m_prs[1] != 0 || fire[0] != 0) ? 1 : 0;
        ed = (m_prs[2] != 0 || fire[1] != 0) ? 1 : 0;

        if (o_st >= 1 && o_st <= 3) m_tin = pack(m_f[0], m_f[1], m_f[2]);

        if (o_st == 0) begin
            m_idle = 0;
            if (em != 0) begin
                m_f[0] = (tcur[16:12] > 5'd23) ? 0 : int'(tcur[16:12]);
                m_f[1] = (tcur[11:6]  > 6'd59) ? 0 : int'(tcur[11:6]);
                m_f[2] = (tcur[5:0]   > 6'd59) ? 0 : int'(tcur[5:0]);
                m_st = 1;
            end
        end else if (o_st == 4) begin
            m_idle = 0;
            m_st = 0;
        end else begin
            if (em != 0) begin
                m_idle = 0;
                m_st = o_st + 1;
            end else if (ei != ed) begin
                m_idle = 0;
                dlt = (ei != 0) ? 1 : -1;
                m_f[o_st-1] = (m_f[o_st-1] + dlt + modv[o_st-1]) % modv[o_st-1];
            end else begin
                m_idle++;
                if (m_idle == int'(TO)) begin
                    m_idle = 0;
                    m_st = 0;
                end
            end
        end
        m_ow  = (m_st == 4) ? 1 : 0;
        m_fld = (m_st >= 1 && m_st <= 3) ? m_st : 0;

        for (int j = 0; j < 2; j++)
            if (m_db[1+j] == 0 || !(o_st >= 1 && o_st <= 3) || m_st != o_st) m_held[j] = 0;
            else m_held[j]++;

        for (int i = 0; i < 3; i++) begin
            m_prs[i] = 0;
            if (m_sy2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(DB)) begin
                    m_db[i]  = 1 - m_db[i];
                    m_run[i] = 0;
                    m_prs[i] = m_db[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_sy2[i] = m_sy1[i];
            m_sy1[i] = int'(btn[i]);
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (bus.time_in !== m_tin || bus.time_ow !== 1'(m_ow) || bus.edit_field !== 2'(m_fld)) begin
                n_err++;
                $display("FAIL cycle_model t=%0t time_in=%h want %h ow=%b want %0d field=%0d want %0d",
                         $time, bus.time_in, m_tin, bus.time_ow, m_ow, bus.edit_field, m_fld);
            end
            if (bus.time_ow === 1'b1) ow_cycles++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        cyc(8);
        btn[b] = 1'b0;
        cyc(8);
    endtask

    initial begin
        int ow0;
        int k;
        int hold [3] = '{0, 0, 0};
        btn  = '0;
        tcur = '0;
        rst  = 1'b1;
        cyc(3);
        chk_en = 1'b1;
        check("rst_time_in", 32'(bus.time_in), 32'd0);
        check("rst_time_ow", 32'(bus.time_ow), 32'd0);
        check("rst_field",   32'(bus.edit_field), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Full edit 12:34:56 -> 14:33:00
        tcur = pack(12, 34, 56);
        press(0);
        check("edit_field_hr", 32'(bus.edit_field), 32'd1);
        check("capture", 32'(bus.time_in), 32'(pack(12, 34, 56)));
        press(1); press(1);
        press(0);
        check("edit_field_min", 32'(bus.edit_field), 32'd2);
        press(2);
        press(0);
        check("edit_field_sec", 32'(bus.edit_field), 32'd3);
        repeat (4) press(1);
        ow0 = ow_cycles;
        press(0);
        check("edit_field_done", 32'(bus.edit_field), 32'd0);
        check("commit_value", 32'(bus.time_in), 32'(pack(14, 33, 0)));
        check("model_commit", 32'(m_tin), 32'(pack(14, 33, 0)));
        check("ow_width", 32'(ow_cycles - ow0), 32'd1);
        cyc(5);
        check("hold_after_ow", 32'(bus.time_in), 32'(pack(14, 33, 0)));

        // Debounce filtering in SET_MIN
        tcur = pack(10, 20, 30);
        press(0); press(0);
        check("glitch_field", 32'(bus.edit_field), 32'd2);
        btn[1] = 1'b1; cyc(3); btn[1] = 1'b0; cyc(10);
        check("glitch3_ignored", 32'(bus.time_in), 32'(pack(10, 20, 30)));
        btn[1] = 1'b1; cyc(4); btn[1] = 1'b0; cyc(10);
        check("hold4_once", 32'(bus.time_in), 32'(pack(10, 21, 30)));
        btn[1] = 1'b1; cyc(6); btn[1] = 1'b0; cyc(10);
        check("hold6_once", 32'(bus.time_in), 32'(pack(10, 22, 30)));
        press(0); press(0);

        // Wrap boundaries
        tcur = pack(0, 59, 30);
        press(0);
        press(2);
        check("hour_wrap_dec", 32'(bus.time_in), 32'(pack(23, 59, 30)));
        press(0);
        press(1);
        check("min_wrap_inc", 32'(bus.time_in), 32'(pack(23, 0, 30)));
        press(0); press(0);
        check("wrap_commit", 32'(bus.time_in), 32'(pack(23, 0, 30)));
        tcur = pack(31, 62, 61);
        press(0);
        check("clamp_capture", 32'(bus.time_in), 32'd0);
        press(0); press(0); press(0);
        check("clamp_done", 32'(bus.edit_field), 32'd0);

        // Simultaneous events
        tcur = pack(5, 6, 7);
        press(0);
        btn[1] = 1'b1; btn[2] = 1'b1; cyc(8); btn[1] = 1'b0; btn[2] = 1'b0; cyc(8);
        check("inc_dec_cancel", 32'(bus.time_in), 32'(pack(5, 6, 7)));
        btn[0] = 1'b1; btn[1] = 1'b1; cyc(8); btn[0] = 1'b0; btn[1] = 1'b0; cyc(8);
        check("mode_beats_inc_field", 32'(bus.edit_field), 32'd2);
        check("mode_beats_inc_value", 32'(bus.time_in), 32'(pack(5, 6, 7)));
        press(0);

        // Reset in SET_SEC
        check("pre_rst_field", 32'(bus.edit_field), 32'd3);
        ow0 = ow_cycles;
        rst = 1'b1; cyc(1);
        check("rst_mid_time_in", 32'(bus.time_in), 32'd0);
        check("rst_mid_ow", 32'(bus.time_ow), 32'd0);
        check("rst_mid_field", 32'(bus.edit_field), 32'd0);
        rst = 1'b0; cyc(5);
        check("rst_no_ow", 32'(ow_cycles - ow0), 32'd0);

        // Timeout from SET_HR
        tcur = pack(7, 8, 9);
        btn[0] = 1'b1;
        k = 0;
        while (bus.edit_field != 2'd1 && k < 40) begin cyc(1); k++; end
        check("to_enter", 32'(bus.edit_field), 32'd1);
        btn[0] = 1'b0;
        ow0 = ow_cycles;
        k = 0;
        while (bus.edit_field == 2'd1 && k < 100) begin cyc(1); k++; end
        check("to_cycles", 32'(k), 32'(TO));
        check("to_no_ow", 32'(ow_cycles - ow0), 32'd0);
        check("to_keep_time_in", 32'(bus.time_in), 32'(pack(7, 8, 9)));

        // Long hold of inc in SET_SEC from 58
        tcur = pack(1, 2, 58);
        press(0); press(0); press(0);
        btn[1] = 1'b1; cyc(20); btn[1] = 1'b0; cyc(12);
`ifdef TIME_SET_AUTO_REPEAT_EN
        check("long_hold", 32'(bus.time_in), 32'(pack(1, 2, 3)));
`else
        check("long_hold", 32'(bus.time_in), 32'(pack(1, 2, 59)));
`endif
        press(0);

        // Random traffic against the model
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 19) == 0) tcur = 17'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = ($urandom_range(0, 99) < ((b == 0) ? 30 : 45));
                    hold[b] = $urandom_range(1, 14);
                end else begin
                    hold[b]--;
                end
            end
            cyc(1);
        end
        rst = 1'b0;
        btn = '0;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel time-setting controller that sits directly upstream of the digital clock core. It debounces three push-buttons, runs an hours/minutes/seconds edit state machine seeded from the clock's current time, and drives the clock's 17-bit `time_in` bus plus a one-cycle `time_ow` overwrite strobe. While no edit is in progress, the block is transparent: `time_ow` stays low and the clock free-runs.

## Interface
- `DEBOUNCE_CYCLES`, 20000: consecutive stable `clk` cycles required before a button change is accepted.
- `TIMEOUT_CYCLES`, 10000000: idle `clk` cycles in an edit state before the edit is abandoned.
- `REPEAT_DELAY`, 5000000: hold time before auto-repeat starts (only with `TIME_SET_AUTO_REPEAT_EN`).
- `REPEAT_CYCLES`, 1000000: auto-repeat period (only with `TIME_SET_AUTO_REPEAT_EN`).
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_mode` in 1: raw asynchronous button that advances the edit field.
- `btn_inc` in 1: raw asynchronous button that increments the selected field.
- `btn_dec` in 1: raw asynchronous button that decrements the selected field.
- `time_cur` in 17: current clock time, `{hour[4:0], min[5:0], sec[5:0]}`.
- `time_in` out 17: time to load, same format.
- `time_ow` out 1: overwrite strobe, one `clk` cycle wide.
- `edit_field` out 2: field being edited. 0 = none, 1 = hours, 2 = minutes, 3 = seconds.

## Operation
- **Synchronisation.** Each button passes through a 2-FF synchroniser.
- **Debounce.** Each synchronised button has its own debounce counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The debounced level flips only after the input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreement between input and debounced level clears the counter.
- **Press events.** A single-cycle press event fires on each debounced rising edge.
- **Event priority.** `mode` beats `inc`/`dec` in the same cycle. `inc` and `dec` in the same cycle are both ignored.
- **States.** The FSM has five states: RUN, SET_HR, SET_MIN, SET_SEC, COMMIT.
- **RUN.**
  - On `mode`: capture `time_cur` into the edit registers, then go to SET_HR.
  - Capture clamp: a captured hour > 23 becomes 0, and a captured minute or second > 59 becomes 0.
  - `inc`/`dec` events are ignored in RUN.
- **SET_HR, SET_MIN, SET_SEC.**
  - `inc`/`dec` modify only the selected field.
  - Hour wraps: 23+1 → 0 and 0−1 → 23.
  - Minute and second wrap: 59+1 → 0 and 0−1 → 59.
  - Arithmetic is performed at field width. Results never leave the legal range.
- **Field advance.** `mode` moves SET_HR → SET_MIN → SET_SEC → COMMIT.
- **COMMIT.** Lasts exactly one cycle with `time_ow` = 1, then goes to RUN unconditionally. Button events arriving in this cycle are dropped.
- **Timeout.** Each edit state has an idle counter that is cleared on any accepted event.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to RUN with no `time_ow`.
  - `time_in` keeps its last value on timeout.
- **`time_in`.** Registered from the edit registers every cycle while in an edit state. It is frozen in COMMIT and RUN.
- **`edit_field`.** Registered encoding of the current state. RUN and COMMIT both encode as 0.

## Timing
- **Reset.** Reset clears `time_in` = 0, `time_ow` = 0, `edit_field` = 0, the FSM to RUN, all counters, debounced levels and synchroniser flops to 0.
- **Reset mid-edit.** Asserting `rst` in any state returns to RUN on the next edge with no `time_ow` pulse.
- **Press latency.**
  - Raw button edge → press event: 2 sync cycles + `DEBOUNCE_CYCLES`.
  - Press event → state/field update: 1 cycle.
  - Field update → `time_in` update: 1 cycle.
- **Set-up and hold for `time_ow`.**
  - `time_in` is stable for at least 1 cycle before `time_ow` rises, because nothing is edited in the cycle that enters COMMIT.
  - `time_in` stays stable indefinitely after `time_ow` falls.
  - The downstream clock treats `time_ow` as an asynchronous load and depends on this hold behaviour.
- **`time_ow` shape.** `time_ow` is a registered output and glitch-free. Its width is exactly 1 `clk` cycle.
- **Seconds rollover.** The captured `time_cur` may advance during editing. Any rollover is overwritten on COMMIT, which is intentional.

## Configuration
- **`TIME_SET_AUTO_REPEAT_EN` defined:**
  - While debounced `inc` or `dec` stays high in an edit state, an extra event fires after `REPEAT_DELAY` cycles.
  - Further events then fire every `REPEAT_CYCLES` cycles until release.
  - The repeat counter clears on release, on a state change, and on `rst`.
  - Repeat events reset the timeout counter.
- **`TIME_SET_AUTO_REPEAT_EN` undefined:**
  - Exactly one event fires per press, regardless of hold time.
  - The repeat counters and the `REPEAT_*` parameters are unused.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=50, `REPEAT_DELAY`=10, `REPEAT_CYCLES`=3.
- **Debounce filtering.** `btn_inc` glitches high for 3 cycles in SET_MIN → no change. Holding it for 4 or more cycles → minute +1 exactly once (auto-repeat off).
- **Full edit and commit.** `time_cur`=12:34:56. Sequence: `mode`, `inc`×2, `mode`, `dec`, `mode`, `inc`×4, `mode` → `time_in`=14:33:00 (the seconds wrap 56→0). `time_ow` is high for exactly 1 cycle, and `edit_field` goes 1, 2, 3, 0.
- **Wrap boundaries.** `dec` at hour 0 → 23. `inc` at minute 59 → 0. `time_cur` hour=31 captured → 0.
- **Simultaneous events.** `inc` and `dec` debounced on the same cycle → no change. `mode` and `inc` on the same cycle → field advances, value unchanged.
- **Timeout and reset.** Enter SET_HR, then idle 50 cycles → RUN with no `time_ow`. Separately, `rst` in SET_SEC → all outputs 0 on the next cycle and no `time_ow` pulse.
- **Auto-repeat (macro defined).** Hold `inc` for 20 debounced cycles in SET_SEC from 58 → events at cycles 0, 10, 13, 16, 19 → seconds go 59, 0, 1, 2, 3.
